// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave sampled entirely in the clk domain: pin synchronizers,
// 16-bit R/W frame decode, five control registers committed atomically at frame end.
module spi_reg_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Synchronizer chains are deliberately not reset: after a mid-frame reset they keep
  // tracking the real pins, so a still-low ncs produces no spurious falling edge.
  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_prev_q, ncs_prev_q;

  always_ff @(posedge clk) begin
    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
    ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
    sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    ncs_prev_q  <= ncs_sync_q[SYNC_STAGES-1];
  end

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  always_comb begin
    sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    copi_s    = copi_sync_q[SYNC_STAGES-1];
    ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_prev_q;
    sclk_fall = ~sclk_s & sclk_prev_q;
    ncs_rise  = ncs_s & ~ncs_prev_q;
    ncs_fall  = ~ncs_s & ncs_prev_q;
  end

  state_t      state_q;
  logic [4:0]  bit_cnt_q;
  logic [15:0] shift_q;
  logic [7:0]  hdr_q;
  logic [7:0]  tx_q;
  logic        rd_loaded_q;
  logic        cipo_q, wr_strobe_q, frame_err_q;
  logic [7:0]  regs_q [5];

  function automatic logic addr_ok(input logic [6:0] a);
    return 32'(a) <= MAX_ADDR;
  endfunction

  function automatic logic [7:0] read_reg(input logic [6:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (addr_ok(a)) begin
      case (a)
        7'd0:    v = regs_q[0];
        7'd1:    v = regs_q[1];
        7'd2:    v = regs_q[2];
        7'd3:    v = regs_q[3];
        7'd4:    v = regs_q[4];
        default: v = 8'h00;
      endcase
    end
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 5'd0;
      rd_loaded_q <= 1'b0;
      cipo_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < 5; i++) regs_q[i] <= 8'h00;
    end else begin
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cipo_q <= 1'b0;
          if (ncs_fall) begin
            state_q     <= SHIFT;
            bit_cnt_q   <= 5'd0;
            shift_q     <= 16'h0000;
            rd_loaded_q <= 1'b0;
          end
        end
        SHIFT: begin
          // ncs rise takes priority; a coincident sclk edge is dropped
          if (ncs_rise) begin
            state_q <= IDLE;
            cipo_q  <= 1'b0;
            if (bit_cnt_q == 5'd16) begin
              if (shift_q[15] && addr_ok(shift_q[14:8])) begin
                case (shift_q[14:8])
                  7'd0:    regs_q[0] <= shift_q[7:0];
                  7'd1:    regs_q[1] <= shift_q[7:0];
                  7'd2:    regs_q[2] <= shift_q[7:0];
                  7'd3:    regs_q[3] <= shift_q[7:0];
                  7'd4:    regs_q[4] <= shift_q[7:0];
                  default: ;
                endcase
                wr_strobe_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              shift_q <= {shift_q[14:0], copi_s};
              if (bit_cnt_q == 5'd7) hdr_q <= {shift_q[6:0], copi_s};
              if (bit_cnt_q != 5'd17) bit_cnt_q <= bit_cnt_q + 5'd1;
            end
            if (sclk_fall && bit_cnt_q >= 5'd8 && !hdr_q[7]) begin
              if (!rd_loaded_q) begin
                tx_q        <= read_reg(hdr_q[6:0]);
                cipo_q      <= read_reg(hdr_q[6:0]) >> 7 != 8'h00;
                rd_loaded_q <= 1'b1;
              end else begin
                tx_q   <= {tx_q[6:0], 1'b0};
                cipo_q <= tx_q[6];
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cipo            = cipo_q;
  assign wr_strobe       = wr_strobe_q;
  assign frame_err       = frame_err_q;
  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: bit-banged SPI frames with hand-computed expectations.
module tb_spi_reg_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic       cipo;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       wr_strobe, frame_err;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int err_cnt = 0;

  spi_reg_slave #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4),
    .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe) wr_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends nbits (MSB first, zeros beyond bit 16); optional reset after rst_at bits.
  task automatic spi_frame(input logic [15:0] tx, input int nbits, input int rst_at,
                           output logic [7:0] rx);
    rx = 8'h00;
    ncs = 1'b0;
    wait_clk(5);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
      end
      copi = (i < 16) ? tx[15-i] : 1'b0;
      wait_clk(5);
      sclk = 1'b1;
      if (i >= 8 && i < 16) rx = {rx[6:0], cipo};
      wait_clk(5);
      sclk = 1'b0;
    end
    wait_clk(5);
    ncs = 1'b1;
    copi = 1'b0;
    wait_clk(8);
  endtask

  logic [7:0] rx;
  int w0, e0;

  initial begin
    wait_clk(2);
    rst = 1'b0;
    wait_clk(4);
    chk("rst_r0", r0, 8'h00);
    chk("rst_r1", r1, 8'h00);
    chk("rst_r2", r2, 8'h00);
    chk("rst_r3", r3, 8'h00);
    chk("rst_r4", r4, 8'h00);
    chk("rst_cipo", cipo, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);

    w0 = wr_cnt;
    spi_frame(16'h80A5, 16, -1, rx);
    chk("wr0_r0", r0, 8'hA5);
    chk("wr0_strobe", wr_cnt - w0, 1);
    w0 = wr_cnt;
    spi_frame(16'h843C, 16, -1, rx);
    chk("wr4_r4", r4, 8'h3C);
    chk("wr4_strobe", wr_cnt - w0, 1);
    chk("wr4_r1", r1, 8'h00);
    chk("wr4_r2", r2, 8'h00);
    chk("wr4_r3", r3, 8'h00);
    chk("wr4_r0_kept", r0, 8'hA5);

    spi_frame(16'h825A, 16, -1, rx);
    chk("wr2_r2", r2, 8'h5A);
    w0 = wr_cnt; e0 = err_cnt;
    spi_frame(16'h0200, 16, -1, rx);
    chk("rd2_data", rx, 8'h5A);
    chk("rd2_no_strobe", wr_cnt - w0, 0);
    chk("rd2_no_err", err_cnt - e0, 0);
    chk("rd2_r2_kept", r2, 8'h5A);
    chk("rd2_cipo_idle", cipo, 0);
    spi_frame(16'h0000, 16, -1, rx);
    chk("rd0_data", rx, 8'hA5);

    w0 = wr_cnt; e0 = err_cnt;
    spi_frame(16'h85FF, 16, -1, rx);
    chk("badaddr_no_strobe", wr_cnt - w0, 0);
    chk("badaddr_no_err", err_cnt - e0, 0);
    chk("badaddr_regs", {r0, r1, r2, r3, r4}, 40'hA500_5A00_3C);
    spi_frame(16'h0700, 16, -1, rx);
    chk("badaddr_rd", rx, 8'h00);

    w0 = wr_cnt; e0 = err_cnt;
    spi_frame(16'h81AB, 12, -1, rx);
    spi_frame(16'h81CD, 20, -1, rx);
    chk("malformed_r1", r1, 8'h00);
    chk("malformed_err", err_cnt - e0, 2);
    chk("malformed_no_strobe", wr_cnt - w0, 0);

    w0 = wr_cnt; e0 = err_cnt;
    spi_frame(16'h8377, 16, 10, rx);
    chk("rstmid_r3", r3, 8'h00);
    chk("rstmid_r0_cleared", r0, 8'h00);
    chk("rstmid_no_strobe", wr_cnt - w0, 0);
    chk("rstmid_no_err", err_cnt - e0, 0);
    w0 = wr_cnt;
    spi_frame(16'h8377, 16, -1, rx);
    chk("after_rst_r3", r3, 8'h77);
    chk("after_rst_strobe", wr_cnt - w0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
